// File: rtl/car_sensor_conditioner.sv
// Country-road vehicle detector conditioner: sync, debounce, latch and hold the request x for sig_control.
// Optional build macro CAR_COUNT_EN adds the saturating car_count arrival counter port.
module car_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 3,
    parameter int unsigned MAX_EXT_CYCLES  = 20
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       sensor_raw,
    input  logic [1:0] cntry,
    output logic       x
`ifdef CAR_COUNT_EN
    ,
    output logic [7:0] car_count
`endif
);

    localparam logic [1:0] GREEN    = 2'd2;
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] EXT_LAST = 8'(MAX_EXT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        QUALIFY,
        REQUEST,
        SERVED,
        HOLDOFF
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] gcnt;
    logic       sync_p0;
    logic       sync_p1;
    logic       s;
    logic       green;
    logic       qual_done;

    function automatic logic is_green(input logic [1:0] code);
        return code == GREEN;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchroniser for the asynchronous detector
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= sensor_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign s         = sync_p1;
    assign green     = is_green(cntry);
    assign qual_done = (cnt == DEB_LAST);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            gcnt  <= 8'd0;
            x     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    x <= 1'b0;
                    if (s) begin
                        state <= QUALIFY;
                        cnt   <= 8'd1;
                    end
                end
                QUALIFY: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        x     <= 1'b0;
                    end else if (qual_done) begin
                        state <= REQUEST;
                        cnt   <= 8'd0;
                        x     <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        x   <= 1'b0;
                    end
                end
                REQUEST: begin
                    // Request stays latched even after the vehicle leaves
                    x <= 1'b1;
                    if (green) begin
                        state <= SERVED;
                        cnt   <= 8'd0;
                        gcnt  <= 8'd0;
                    end
                end
                SERVED: begin
                    if (!green || (!s && gcnt == GAP_LAST)) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                        gcnt  <= 8'd0;
                        x     <= 1'b0;
                    end else if (cnt == EXT_LAST) begin
                        state <= HOLDOFF;
                        cnt   <= 8'd0;
                        gcnt  <= 8'd0;
                        x     <= 1'b0;
                    end else begin
                        cnt  <= cnt + 8'd1;
                        gcnt <= s ? 8'd0 : gcnt + 8'd1;
                        x    <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    // Blocks a fresh request until the green phase ends
                    x <= 1'b0;
                    if (!green) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                    gcnt  <= 8'd0;
                    x     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAR_COUNT_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            car_count <= 8'd0;
        end else if (state == QUALIFY && s && qual_done) begin
            car_count <= sat_inc8(car_count);
        end
    end
`endif

endmodule

// File: tb/tb_car_sensor_conditioner.sv
// Scoreboard bench for car_sensor_conditioner: directed stimulus queues expected x (and car_count when built).
module tb_car_sensor_conditioner;

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;
    localparam logic [1:0] ILL = 2'd3;

    logic       clk        = 1'b0;
    logic       clear_n    = 1'b0;
    logic       sensor_raw = 1'b0;
    logic [1:0] cntry      = 2'd0;
    logic       x;
`ifdef CAR_COUNT_EN
    logic [7:0] car_count;
`endif

    car_sensor_conditioner dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .sensor_raw (sensor_raw),
        .cntry      (cntry),
        .x          (x)
`ifdef CAR_COUNT_EN
        ,
        .car_count  (car_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       x;
        logic [7:0] cc;
        string      nm;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic       prev_e = 1'b0;
    logic [7:0] exp_cc = 8'd0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    endtask

    // One cycle of stimulus; expected outputs apply after the following rising edge
    task automatic cyc(input logic rn, input logic r, input logic [1:0] c, input logic e, input string nm);
        exp_t t;
        @(negedge clk);
        clear_n    = rn;
        sensor_raw = r;
        cntry      = c;
        if (!rn) exp_cc = 8'd0;
        else if (e && !prev_e && exp_cc != 8'hff) exp_cc = exp_cc + 8'd1;
        prev_e = rn ? e : 1'b0;
        t.x  = e;
        t.cc = exp_cc;
        t.nm = nm;
        exp_q.push_back(t);
    endtask

    task automatic rep(input int n, input logic rn, input logic r, input logic [1:0] c, input logic e, input string nm);
        for (int i = 0; i < n; i++) cyc(rn, r, c, e, nm);
    endtask

    // Full arrival from IDLE with a quiet synchroniser, served briefly, then released by YELLOW
    task automatic arrival();
        rep(5, 1'b1, 1'b1, RED, 1'b0, "arr_qual");
        cyc(1'b1, 1'b1, RED, 1'b1, "arr_rise");
        cyc(1'b1, 1'b0, GRN, 1'b1, "arr_served");
        cyc(1'b1, 1'b0, YEL, 1'b0, "arr_exit");
        rep(2, 1'b1, 1'b0, RED, 1'b0, "arr_idle");
    endtask

    initial begin : monitor
        exp_t t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                t = exp_q.pop_front();
                check({t.nm, "_x"}, {7'd0, x}, {7'd0, t.x});
`ifdef CAR_COUNT_EN
                check({t.nm, "_cc"}, car_count, t.cc);
`endif
            end
        end
    end

    initial begin : async_monitor
        forever begin
            @(negedge clear_n);
            #1;
            check("async_rst_x", {7'd0, x}, 8'd0);
`ifdef CAR_COUNT_EN
            check("async_rst_cc", car_count, 8'd0);
`endif
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : stimulus
        int waited;
        rep(3, 1'b0, 1'b0, RED, 1'b0, "rst");

        // Reset held with a vehicle and green present, then release and measure latency
        rep(4, 1'b0, 1'b1, GRN, 1'b0, "t1_rst_hold");
        rep(5, 1'b1, 1'b1, GRN, 1'b0, "t1_lat");
        cyc(1'b1, 1'b1, GRN, 1'b1, "t1_rise");

        // Continuous traffic on green: maximum extension then holdoff
        rep(20, 1'b1, 1'b1, GRN, 1'b1, "t5_served");
        cyc(1'b1, 1'b1, GRN, 1'b0, "t5_maxext");
        rep(5, 1'b1, 1'b1, GRN, 1'b0, "t5_holdoff");
        cyc(1'b1, 1'b1, RED, 1'b0, "t5_idle");
        rep(3, 1'b1, 1'b1, RED, 1'b0, "t5_requal");
        cyc(1'b1, 1'b1, RED, 1'b1, "t5_rerequest");

        // Latched request on red, then gap timeout once green
        rep(30, 1'b1, 1'b0, RED, 1'b1, "t3_latch");
        cyc(1'b1, 1'b0, GRN, 1'b1, "t3_served");
        rep(2, 1'b1, 1'b0, GRN, 1'b1, "t3_gap");
        cyc(1'b1, 1'b0, GRN, 1'b0, "t3_fall");

        // Short glitch rejected, exact debounce length accepted
        rep(3, 1'b1, 1'b1, RED, 1'b0, "t2_glitch");
        rep(6, 1'b1, 1'b0, RED, 1'b0, "t2_idle");
        rep(4, 1'b1, 1'b1, RED, 1'b0, "t2_four");
        cyc(1'b1, 1'b0, RED, 1'b0, "t2_four_wait");
        cyc(1'b1, 1'b0, RED, 1'b1, "t2_four_rise");
        rep(3, 1'b1, 1'b0, RED, 1'b1, "t2_latched");

        // Gap of two samples keeps x, gap of three ends it
        rep(3, 1'b1, 1'b1, RED, 1'b1, "t4_pre");
        cyc(1'b1, 1'b1, GRN, 1'b1, "t4_served");
        rep(2, 1'b1, 1'b0, GRN, 1'b1, "t4_short_gap");
        rep(3, 1'b1, 1'b1, GRN, 1'b1, "t4_refill");
        rep(4, 1'b1, 1'b0, GRN, 1'b1, "t4_long_gap");
        cyc(1'b1, 1'b0, GRN, 1'b0, "t4_fall");

        // Illegal code and yellow both count as not green
        rep(5, 1'b1, 1'b1, RED, 1'b0, "ill_qual");
        cyc(1'b1, 1'b1, RED, 1'b1, "ill_req");
        rep(2, 1'b1, 1'b1, GRN, 1'b1, "ill_served");
        cyc(1'b1, 1'b1, ILL, 1'b0, "ill_exit");
        rep(3, 1'b1, 1'b1, YEL, 1'b0, "yel_requal");
        cyc(1'b1, 1'b1, YEL, 1'b1, "yel_req");
        rep(2, 1'b1, 1'b1, YEL, 1'b1, "yel_hold");

        // Asynchronous reset asserted between clock edges while in REQUEST
        @(negedge clk);
        #2;
        clear_n = 1'b0;
        rep(2, 1'b0, 1'b0, RED, 1'b0, "t6_rst");
        rep(2, 1'b1, 1'b0, RED, 1'b0, "t6_rel");
        arrival();
        arrival();
        arrival();
        rep(2, 1'b0, 1'b0, RED, 1'b0, "t6_clr");
        rep(2, 1'b1, 1'b0, RED, 1'b0, "t6_end");

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
